// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans 12 keys, allocates NUM_VOICES tone voices with age-based stealing.
// Optional build macro VOICE_STEAL_EN: steal the oldest voice on a press with no free voice (else drop).
`timescale 1ns/1ps

module voice_allocator #(
    parameter int NUM_VOICES = 2,
    parameter int HP_W       = 19
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [11:0]                key_state,
    input  logic [1:0]                 octave,
    output logic [NUM_VOICES-1:0]      voice_valid,
    output logic [4*NUM_VOICES-1:0]    voice_note,
    output logic [HP_W*NUM_VOICES-1:0] voice_half_period,
    output logic                       full_event
);

    localparam int RW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [3:0]    LAST_KEY = 4'd11;
    localparam logic [RW-1:0] OLDEST   = RW'(NUM_VOICES - 1);

    function automatic logic [14:0] base_hp(input logic [3:0] note);
        case (note)
            4'd0:    base_hp = 15'd23889;
            4'd1:    base_hp = 15'd22548;
            4'd2:    base_hp = 15'd21283;
            4'd3:    base_hp = 15'd20088;
            4'd4:    base_hp = 15'd18961;
            4'd5:    base_hp = 15'd17897;
            4'd6:    base_hp = 15'd16892;
            4'd7:    base_hp = 15'd15944;
            4'd8:    base_hp = 15'd15049;
            4'd9:    base_hp = 15'd14205;
            4'd10:   base_hp = 15'd13407;
            4'd11:   base_hp = 15'd12655;
            default: base_hp = 15'd0;
        endcase
    endfunction

    logic [3:0]            r_idx;
    logic [11:0]           r_snap;
    logic [11:0]           r_prev;
    logic [NUM_VOICES-1:0] r_valid;
    logic [3:0]            r_note [NUM_VOICES];
    logic [RW-1:0]         r_rank [NUM_VOICES];
    logic [HP_W-1:0]       r_hp   [NUM_VOICES];
    logic                  r_full;

    logic                  w_press;
    logic                  w_release;
    logic                  w_free_found;
    logic [RW-1:0]         w_free_idx;
    logic                  w_alloc;
    logic [RW-1:0]         w_target;
    logic [NUM_VOICES-1:0] w_valid_nxt;
    logic [3:0]            w_note_nxt [NUM_VOICES];
    logic [RW-1:0]         w_rank_nxt [NUM_VOICES];

    // Edge detection compares the latched scan snapshot with the last processed level of key idx.
    assign w_press   =  r_snap[r_idx] & ~r_prev[r_idx];
    assign w_release = ~r_snap[r_idx] &  r_prev[r_idx];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_idx  <= LAST_KEY;
            r_snap <= '0;
            r_prev <= '0;
        end else begin
            r_prev[r_idx] <= r_snap[r_idx];
            if (r_idx == LAST_KEY) begin
                r_idx  <= '0;
                r_snap <= key_state;
            end else begin
                r_idx <= r_idx + 4'd1;
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_valid[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = RW'(v);
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic [RW-1:0] w_oldest_idx;

    always_comb begin
        w_oldest_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (r_rank[v] == OLDEST) begin
                w_oldest_idx = RW'(v);
            end
        end
    end

    always_comb begin
        w_alloc  = w_press;
        w_target = w_free_found ? w_free_idx : w_oldest_idx;
    end
`else
    always_comb begin
        w_alloc  = w_press & w_free_found;
        w_target = w_free_idx;
    end
`endif

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_valid_nxt[v] = r_valid[v];
            w_note_nxt[v]  = r_note[v];
            w_rank_nxt[v]  = r_rank[v];
        end
        if (w_release) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_valid[v] && (r_note[v] == r_idx)) begin
                    w_valid_nxt[v] = 1'b0;
                end
            end
        end
        // Allocated voice becomes the youngest; only voices younger than it age by one.
        if (w_alloc) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (RW'(v) == w_target) begin
                    w_valid_nxt[v] = 1'b1;
                    w_note_nxt[v]  = r_idx;
                    w_rank_nxt[v]  = '0;
                end else if (r_rank[v] < r_rank[w_target]) begin
                    w_rank_nxt[v] = r_rank[v] + 1'b1;
                end
            end
        end
    end

    // NOTE: the voice arrays are reset explicitly because ranks must start as a valid permutation.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_valid <= '0;
            r_full  <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= '0;
                r_rank[v] <= RW'(v);
            end
        end else begin
            r_valid <= w_valid_nxt;
            r_full  <= w_press & ~w_free_found;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_note[v] <= w_note_nxt[v];
                r_rank[v] <= w_rank_nxt[v];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_hp[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_hp[v] <= r_valid[v]
                         ? ({{(HP_W-15){1'b0}}, base_hp(r_note[v])} << octave)
                         : '0;
            end
        end
    end

    always_comb begin
        voice_note        = '0;
        voice_half_period = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note[4*v +: 4]              = r_note[v];
            voice_half_period[HP_W*v +: HP_W] = r_hp[v];
        end
    end

    assign voice_valid = r_valid;
    assign full_event  = r_full;

endmodule
